// File: rtl/rf_vector_driver.sv
// rf_vector_driver: issue side of the Random Forest accelerator.
// Drives one tagged feature vector at a time onto the accelerator, waits
// its fixed latency, returns the class with the tag and keeps per-class
// saturating hit counters.
//
// Ports:
//   sysclk, rst          clock and synchronous active-high reset
//   s_valid/s_ready      upstream handshake; s_data feature vector, s_tag tag
//   acc_data             registered drive to the accelerator data_input
//   acc_class            accelerator class_out
//   m_valid/m_ready      downstream handshake; m_class result, m_tag its tag
//   clr_cnt              synchronous clear of all class counters
//   cls_cnt              packed counters, class k at [k*CNT_W +: CNT_W]
//   busy                 high whenever the FSM is not idle
module rf_vector_driver #(
    parameter int FEAT_W  = 36,
    parameter int CLASS_W = 2,
    parameter int ACC_LAT = 4,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                             sysclk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [FEAT_W-1:0]                s_data,
    input  logic [TAG_W-1:0]                 s_tag,
    output logic [FEAT_W-1:0]                acc_data,
    input  logic [CLASS_W-1:0]               acc_class,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [CLASS_W-1:0]               m_class,
    output logic [TAG_W-1:0]                 m_tag,
    input  logic                             clr_cnt,
    output logic [(2**CLASS_W)*CNT_W-1:0]    cls_cnt,
    output logic                             busy
);

    localparam int NCLS = 2**CLASS_W;
    localparam logic [7:0] LAT_LAST = 8'(ACC_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    logic [7:0]         lat_cnt;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   cnt_q [NCLS];
    logic               capture;

    // Capture happens on the WAIT edge that completes the latency window.
    assign capture = (state == WAIT) && (lat_cnt == LAT_LAST);

    assign s_ready = (state == IDLE);
    assign busy    = (state != IDLE);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            tag_q    <= '0;
            acc_data <= '0;
            m_valid  <= 1'b0;
            m_class  <= '0;
            m_tag    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s_valid) begin
                        acc_data <= s_data;
                        tag_q    <= s_tag;
                        lat_cnt  <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt + 8'd1;
                    if (capture) begin
                        m_class <= acc_class;
                        m_tag   <= tag_q;
                        m_valid <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear has priority over a coinciding capture; counters never wrap.
    always_ff @(posedge sysclk) begin
        if (rst || clr_cnt) begin
            for (int k = 0; k < NCLS; k++) cnt_q[k] <= '0;
        end else if (capture && (cnt_q[acc_class] != CNT_MAX)) begin
            cnt_q[acc_class] <= cnt_q[acc_class] + 1'b1;
        end
    end

    always_comb begin
        cls_cnt = '0;
        for (int k = 0; k < NCLS; k++) cls_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end

endmodule

// File: tb/tb_rf_vector_driver.sv
// tb_rf_vector_driver: directed self-checking bench for rf_vector_driver.
// Accelerator model: class = data[13:12], delivered ACC_LAT edges later.
module tb_rf_vector_driver;

    localparam int LAT = 4;
    // Narrow counters so saturation is reachable in a short run.
    localparam int CW  = 4;

    logic          sysclk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [35:0]   s_data;
    logic [7:0]    s_tag;
    logic [35:0]   acc_data;
    logic [1:0]    acc_class;
    logic          m_valid;
    logic          m_ready;
    logic [1:0]    m_class;
    logic [7:0]    m_tag;
    logic          clr_cnt;
    logic [4*CW-1:0] cls_cnt;
    logic          busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    rf_vector_driver #(
        .FEAT_W(36), .CLASS_W(2), .ACC_LAT(LAT), .TAG_W(8), .CNT_W(CW)
    ) dut (
        .sysclk(sysclk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_tag(s_tag),
        .acc_data(acc_data), .acc_class(acc_class),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_class(m_class), .m_tag(m_tag),
        .clr_cnt(clr_cnt), .cls_cnt(cls_cnt), .busy(busy)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    // Accelerator: result valid before the ACC_LAT-th edge after acc_data changes.
    logic [1:0] pipe [LAT-1];
    always @(posedge sysclk) begin
        pipe[0] <= acc_data[13:12];
        for (int i = 1; i < LAT-1; i++) pipe[i] <= pipe[i-1];
    end
    assign acc_class = pipe[LAT-2];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic run_one(input logic [35:0] d, input logic [7:0] t,
                           input logic [1:0] c, input string nm);
        int k;
        s_data = d;
        s_tag = t;
        s_valid = 1'b1;
        k = 0;
        while (!s_ready && k < 20) begin tick(); k++; end
        chk({nm, "_ready"}, 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
        k = 0;
        while (!m_valid && k < 20) begin tick(); k++; end
        chk({nm, "_lat"}, 64'(k), 64'(LAT));
        chk({nm, "_class"}, 64'(m_class), 64'(c));
        chk({nm, "_tag"}, 64'(m_tag), 64'(t));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk({nm, "_mv_drop"}, 64'(m_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int t_acc;
        int prev;
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = 36'hABCDE1234;
        s_tag = 8'hEE;
        m_ready = 1'b0;
        clr_cnt = 1'b0;

        // Reset held with s_valid high
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_s_ready", 64'(s_ready), 64'd1);
            chk("rst_m_valid", 64'(m_valid), 64'd0);
            chk("rst_acc_data", 64'(acc_data), 64'd0);
            chk("rst_cls_cnt", 64'(cls_cnt), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
        end
        rst = 1'b0;
        s_valid = 1'b0;
        tick();
        chk("idle_m_tag", 64'(m_tag), 64'd0);
        chk("idle_m_class", 64'(m_class), 64'd0);

        // Single vector
        s_data = 36'h4271F9000;
        s_tag = 8'h3C;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("single_acc_data", 64'(acc_data), 64'h4271F9000);
        chk("single_busy", 64'(busy), 64'd1);
        chk("single_s_ready", 64'(s_ready), 64'd0);
        for (int i = 1; i < LAT; i++) begin
            tick();
            chk("single_early", 64'(m_valid), 64'd0);
        end
        tick();
        chk("single_m_valid", 64'(m_valid), 64'd1);
        chk("single_m_class", 64'(m_class), 64'd1);
        chk("single_m_tag", 64'(m_tag), 64'h3C);
        chk("single_cnt", 64'(cls_cnt), 64'h0010);

        // Back-pressure with a new vector already offered
        s_data = 36'h000003000;
        s_tag = 8'h55;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_m_valid", 64'(m_valid), 64'd1);
            chk("bp_m_class", 64'(m_class), 64'd1);
            chk("bp_m_tag", 64'(m_tag), 64'h3C);
            chk("bp_s_ready", 64'(s_ready), 64'd0);
        end
        m_ready = 1'b1;
        tick();
        chk("bp_hs_m_valid", 64'(m_valid), 64'd0);
        chk("bp_hs_s_ready", 64'(s_ready), 64'd1);
        chk("bp_hs_no_acc", 64'(acc_data), 64'h4271F9000);
        tick();
        s_valid = 1'b0;
        chk("bp_next_acc", 64'(acc_data), 64'h000003000);
        chk("bp_next_busy", 64'(busy), 64'd1);
        k = 0;
        while (!m_valid && k < 20) begin tick(); k++; end
        chk("bp_next_lat", 64'(k), 64'(LAT));
        chk("bp_next_class", 64'(m_class), 64'd3);
        chk("bp_next_tag", 64'(m_tag), 64'h55);
        tick();
        m_ready = 1'b0;
        chk("bp_next_drop", 64'(m_valid), 64'd0);
        chk("bp_cnt", 64'(cls_cnt), 64'h1010);

        // Clear counters
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_cnt", 64'(cls_cnt), 64'd0);

        // Streaming with s_valid and m_ready held high
        m_ready = 1'b1;
        s_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            s_data = 36'(i) << 12;
            s_tag = 8'(i);
            k = 0;
            while (!s_ready && k < 20) begin tick(); k++; end
            tick();
            t_acc = cyc;
            if (i > 0) chk("stream_gap", 64'(t_acc - prev), 64'(LAT + 2));
            prev = t_acc;
            k = 0;
            while (!m_valid && k < 20) begin tick(); k++; end
            chk("stream_lat", 64'(k), 64'(LAT));
            chk("stream_class", 64'(m_class), 64'(i));
            chk("stream_tag", 64'(m_tag), 64'(i));
        end
        s_valid = 1'b0;
        tick();
        m_ready = 1'b0;
        chk("stream_cnt", 64'(cls_cnt), 64'h1111);

        // Saturation of class 2
        for (int i = 0; i < 14; i++)
            run_one(36'h000002000, 8'(8'h80 + i), 2'd2, "sat");
        chk("sat_reach", 64'(cls_cnt), 64'h1F11);
        for (int i = 0; i < 2; i++)
            run_one(36'h000002000, 8'h90, 2'd2, "sat_hold");
        chk("sat_nowrap", 64'(cls_cnt), 64'h1F11);

        // Clear coinciding with a capture
        s_data = 36'h000001000;
        s_tag = 8'hA1;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clrcap_m_valid", 64'(m_valid), 64'd1);
        chk("clrcap_class", 64'(m_class), 64'd1);
        chk("clrcap_cnt", 64'(cls_cnt), 64'd0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // Reset while in WAIT
        s_data = 36'h000003000;
        s_tag = 8'h77;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("mid_busy", 64'(busy), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_s_ready", 64'(s_ready), 64'd1);
        chk("mid_busy_clr", 64'(busy), 64'd0);
        chk("mid_m_valid", 64'(m_valid), 64'd0);
        chk("mid_acc_data", 64'(acc_data), 64'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mid_no_result", 64'(m_valid), 64'd0);
        end
        run_one(36'h000002000, 8'h99, 2'd2, "post_rst");
        chk("post_rst_cnt", 64'(cls_cnt), 64'h0100);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
